// File: rtl/fft8_stage_ctrl_pkg.sv
// Shared state encoding, sizing constants and bit-reversal helper for the
// 8-point radix-2 DIT FFT sequencer.
package fft_ctrl_pkg;

   localparam int unsigned N_DFLT = 3;
   localparam int unsigned NPTS   = 2**N_DFLT;
   localparam int unsigned MAXN   = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CALC,
      DRAIN,
      UNLOAD
   } state_e;

   // Reverses the low w bits of v; bits at and above w come back zero.
   function automatic logic [MAXN-1:0] bitrev(input logic [MAXN-1:0] v,
                                              input int unsigned     w);
      logic [MAXN-1:0] r;
      logic [MAXN-1:0] t;
      r = '0;
      t = v;
      for (int unsigned i = 0; i < MAXN; i++) begin
         if (i < w) begin
            r = {r[MAXN-2:0], t[0]};
            t = t >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft8_stage_ctrl_addr_gen.sv
// Butterfly operand/twiddle address generator: maps (stage, butterfly index)
// to the upper/lower RAM legs and the W^k twiddle index. Purely combinational.
module fft_addr_gen
#(
   parameter int unsigned N = 3
) (
   input  logic [1:0]   stage_i,
   input  logic [N-2:0] k_i,
   output logic [N-1:0] ia_o,
   output logic [N-1:0] ib_o,
   output logic [N-2:0] tw_o
);

   localparam logic [N-1:0] ONE_N = N'(1);

   logic [N-1:0] k_ext;
   logic [N-1:0] half;
   logic [N-1:0] pos;
   logic [N-1:0] grp;
   logic [N-1:0] ia;
   int unsigned  sh_tw;

   always_comb begin
      k_ext = {1'b0, k_i};
      half  = ONE_N << stage_i;
      pos   = k_ext & (half - ONE_N);
      grp   = k_ext >> stage_i;
      // grp * 2 * half is a left shift by stage+1
      ia    = (grp << ({1'b0, stage_i} + 3'd1)) | pos;
      sh_tw = (N - 1) - 32'(stage_i);
      ia_o  = ia;
      ib_o  = ia + half;
      tw_o  = (N-1)'(pos << sh_tw);
   end

endmodule

// File: rtl/fft8_stage_ctrl.sv
// Frame sequencer for the 8-point FFT: bit-reversed load, 3 stages x 4
// butterflies with a per-stage drain barrier, then natural-order unload.
module fft8_stage_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int unsigned  N          = N_DFLT,
   parameter logic [N-1:0] SCALE_MASK = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         err,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         ram_we,
   output logic [N-1:0] ram_wa,
   output logic         bf_issue,
   input  logic         bf_ready,
   output logic [N-1:0] bf_ia,
   output logic [N-1:0] bf_ib,
   output logic [N-2:0] bf_tw,
   output logic         bf_shift,
   output logic [1:0]   bf_stage,
   input  logic         bf_ret,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] ram_ra,
   output logic         out_last
);

   localparam logic [N-1:0] ONE_N   = N'(1);
   localparam logic [N-2:0] ONE_K   = (N-1)'(1);
   localparam logic [N-1:0] LAST_PT = '1;
   localparam logic [N-2:0] LAST_K  = '1;
   localparam logic [1:0]   LAST_S  = 2'(N - 1);

   state_e       state_q, state_d;
   logic [N-1:0] ld_cnt_q, ld_cnt_d;
   logic [N-1:0] ra_q, ra_d;
   logic [N-1:0] infl_q, infl_d;
   logic [N-2:0] k_q, k_d;
   logic [1:0]   s_q, s_d;
   logic         busy_q, busy_d;
   logic         in_ready_q, in_ready_d;
   logic         bf_issue_q, bf_issue_d;
   logic         out_valid_q, out_valid_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   logic         issue_acc;
   logic         wr_acc;
   logic [N-1:0] ia;
   logic [N-1:0] ib;
   logic [N-2:0] tw;

   assign issue_acc = bf_issue_q & bf_ready;
   assign wr_acc    = in_valid & in_ready_q;

   fft_addr_gen #(
      .N (N)
   ) u_addr_gen (
      .stage_i (s_q),
      .k_i     (k_q),
      .ia_o    (ia),
      .ib_o    (ib),
      .tw_o    (tw)
   );

   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      ra_d     = ra_q;
      infl_d   = infl_q;
      k_d      = k_q;
      s_d      = s_q;
      done_d   = 1'b0;
      err_d    = err_q;

      // A return with nothing outstanding is a datapath protocol fault
      if (issue_acc && !bf_ret) begin
         infl_d = infl_q + ONE_N;
      end else if (bf_ret && !issue_acc) begin
         if (infl_q == '0) begin
            err_d = 1'b1;
         end else begin
            infl_d = infl_q - ONE_N;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD;
               err_d    = 1'b0;
               ld_cnt_d = '0;
               ra_d     = '0;
               infl_d   = '0;
               k_d      = '0;
               s_d      = '0;
            end
         end
         LOAD: begin
            if (wr_acc) begin
               ld_cnt_d = ld_cnt_q + ONE_N;
               if (ld_cnt_q == LAST_PT) begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (issue_acc) begin
               k_d = k_q + ONE_K;
               if (k_q == LAST_K) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (infl_q == '0) begin
               if (s_q == LAST_S) begin
                  state_d = UNLOAD;
                  ra_d    = '0;
               end else begin
                  s_d     = s_q + 2'd1;
                  state_d = CALC;
               end
            end
         end
         UNLOAD: begin
            if (out_ready) begin
               ra_d = ra_q + ONE_N;
               if (ra_q == LAST_PT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      in_ready_d  = (state_d == LOAD);
      bf_issue_d  = (state_d == CALC);
      out_valid_d = (state_d == UNLOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ld_cnt_q    <= '0;
         ra_q        <= '0;
         infl_q      <= '0;
         k_q         <= '0;
         s_q         <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         bf_issue_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         ra_q        <= ra_d;
         infl_q      <= infl_d;
         k_q         <= k_d;
         s_q         <= s_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         bf_issue_q  <= bf_issue_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign in_ready  = in_ready_q;
   assign ram_we    = wr_acc;
   assign ram_wa    = N'(bitrev(MAXN'(ld_cnt_q), N));
   assign bf_issue  = bf_issue_q;
   // Butterfly fields are zeroed whenever no request is being presented
   assign bf_ia     = bf_issue_q ? ia : '0;
   assign bf_ib     = bf_issue_q ? ib : '0;
   assign bf_tw     = bf_issue_q ? tw : '0;
   assign bf_shift  = bf_issue_q & SCALE_MASK[s_q];
   assign bf_stage  = s_q;
   assign out_valid = out_valid_q;
   assign ram_ra    = ra_q;
   assign out_last  = out_valid_q & (ra_q == LAST_PT);

endmodule

// File: tb/tb_fft8_stage_ctrl.sv
// Directed self-checking bench for fft8_stage_ctrl: load order, butterfly
// schedule, stage barrier, scaling mask, unload stall, error and reset cases.
module tb_fft8_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, bf_ready, bf_ret, out_ready;
   logic       busy, done, err, in_ready, ram_we, bf_issue, bf_shift, out_valid, out_last;
   logic [2:0] ram_wa, bf_ia, bf_ib, ram_ra;
   logic [1:0] bf_tw, bf_stage;

   logic       m_busy, m_done, m_err, m_in_ready, m_ram_we, m_bf_issue, m_bf_shift;
   logic       m_out_valid, m_out_last;
   logic [2:0] m_ram_wa, m_bf_ia, m_bf_ib, m_ram_ra;
   logic [1:0] m_bf_tw, m_bf_stage;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] ret_pipe;
   logic [2:0] ret_idx;
   logic       ret_en, ret_force;

   int exp_wa  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
   int exp_ia  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_ib  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int exp_sh2 [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

   always #5 clk = ~clk;

   // Datapath stand-in: each accepted butterfly returns ret_idx+1 cycles later
   always @(posedge clk or posedge rst) begin
      if (rst) ret_pipe <= '0;
      else     ret_pipe <= {ret_pipe[6:0], bf_issue & bf_ready};
   end
   assign bf_ret = ret_force | (ret_en & ret_pipe[ret_idx]);

   fft8_stage_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_ready(in_ready), .ram_we(ram_we), .ram_wa(ram_wa),
      .bf_issue(bf_issue), .bf_ready(bf_ready), .bf_ia(bf_ia), .bf_ib(bf_ib),
      .bf_tw(bf_tw), .bf_shift(bf_shift), .bf_stage(bf_stage), .bf_ret(bf_ret),
      .out_valid(out_valid), .out_ready(out_ready), .ram_ra(ram_ra), .out_last(out_last)
   );

   fft8_stage_ctrl #(.N(3), .SCALE_MASK(3'b101)) dut_m (
      .clk(clk), .rst(rst), .start(start), .busy(m_busy), .done(m_done), .err(m_err),
      .in_valid(in_valid), .in_ready(m_in_ready), .ram_we(m_ram_we), .ram_wa(m_ram_wa),
      .bf_issue(m_bf_issue), .bf_ready(bf_ready), .bf_ia(m_bf_ia), .bf_ib(m_bf_ib),
      .bf_tw(m_bf_tw), .bf_shift(m_bf_shift), .bf_stage(m_bf_stage), .bf_ret(bf_ret),
      .out_valid(m_out_valid), .out_ready(out_ready), .ram_ra(m_ram_ra), .out_last(m_out_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_busy"},      busy,      0);
      chk({pfx, "_done"},      done,      0);
      chk({pfx, "_err"},       err,       0);
      chk({pfx, "_in_ready"},  in_ready,  0);
      chk({pfx, "_ram_we"},    ram_we,    0);
      chk({pfx, "_ram_wa"},    ram_wa,    0);
      chk({pfx, "_bf_issue"},  bf_issue,  0);
      chk({pfx, "_bf_ia"},     bf_ia,     0);
      chk({pfx, "_bf_ib"},     bf_ib,     0);
      chk({pfx, "_bf_tw"},     bf_tw,     0);
      chk({pfx, "_bf_shift"},  bf_shift,  0);
      chk({pfx, "_bf_stage"},  bf_stage,  0);
      chk({pfx, "_out_valid"}, out_valid, 0);
      chk({pfx, "_ram_ra"},    ram_ra,    0);
      chk({pfx, "_out_last"},  out_last,  0);
   endtask

   task automatic load_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_in_ready", in_ready, 1);
      chk("load_err_cleared", err, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("load_ram_we", ram_we, 1);
         chk("load_ram_wa", ram_wa, exp_wa[i]);
         tick();
      end
      chk("load_in_ready_drop", in_ready, 0);
      #1;
      chk("load_we_outside", ram_we, 0);
      in_valid = 1'b0;
      chk("calc_issue_on", bf_issue, 1);
   endtask

   task automatic calc_phase(input bit toggle, input bit poke_start);
      int idx  = 0;
      int rets = 0;
      int cyc  = 0;
      bf_ready = 1'b1;
      while (!out_valid && cyc < 400) begin
         #1;
         if (bf_issue && bf_ready) begin
            if (idx < 12) begin
               chk("issue_ia",     bf_ia,      exp_ia[idx]);
               chk("issue_ib",     bf_ib,      exp_ib[idx]);
               chk("issue_tw",     bf_tw,      exp_tw[idx]);
               chk("issue_stage",  bf_stage,   idx / 4);
               chk("issue_shift",  bf_shift,   1);
               chk("issue_shift_m", m_bf_shift, exp_sh2[idx]);
               chk("stage_barrier", (rets >= 4 * (idx / 4)), 1);
            end
            idx++;
         end
         if (bf_ret) rets++;
         start = (poke_start && cyc == 3);
         tick();
         if (toggle) bf_ready = ~bf_ready;
         cyc++;
      end
      start    = 1'b0;
      bf_ready = 1'b0;
      chk("calc_timeout", (cyc < 400), 1);
      chk("issue_count", idx, 12);
      chk("ret_count", rets, 12);
      chk("calc_err", err, 0);
      chk("calc_busy", busy, 1);
   endtask

   task automatic unload_phase(input bit stall);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("unload_valid", out_valid, 1);
         chk("unload_ra",    ram_ra,    i);
         chk("unload_last",  out_last,  (i == 7));
         chk("unload_done",  done,      0);
         if (stall && i == 5) begin
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               tick();
               #1;
               chk("stall_ra",    ram_ra,    5);
               chk("stall_valid", out_valid, 1);
               chk("stall_last",  out_last,  0);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
      chk("done_pulse",   done,      1);
      chk("end_busy",     busy,      0);
      chk("end_valid",    out_valid, 0);
      tick();
      chk("done_one_cyc", done,      0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      bf_ready  = 1'b0;
      out_ready = 1'b0;
      ret_en    = 1'b0;
      ret_force = 1'b0;
      ret_idx   = 3'd1;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("rst");
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      in_valid = 1'b1;
      #1;
      chk("idle_we_ignored", ram_we, 0);
      chk("idle_in_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      chk("idle_still", busy, 0);

      // Frame 1: always ready, returns 2 cycles after issue
      ret_en  = 1'b1;
      ret_idx = 3'd1;
      load_frame();
      calc_phase(1'b0, 1'b0);
      unload_phase(1'b0);

      // Frame 2: ready toggling, returns 5 cycles late, start poked in CALC, unload stall
      ret_idx = 3'd4;
      load_frame();
      calc_phase(1'b1, 1'b1);
      unload_phase(1'b1);

      // Stray return while idle
      ret_en    = 1'b0;
      ret_force = 1'b1;
      tick();
      ret_force = 1'b0;
      chk("idle_ret_err", err, 1);
      chk("idle_ret_busy", busy, 0);
      tick();
      chk("err_sticky", err, 1);

      // Frame 3: returns withheld so the sequencer parks in DRAIN, then reset
      load_frame();
      bf_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bf_ready = 1'b0;
      chk("drain_issue_off", bf_issue, 0);
      chk("drain_busy", busy, 1);
      chk("drain_ia_zero", bf_ia, 0);
      tick();
      chk("drain_held", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
